reg_file_storage: RTL and testbench

- Register storage array directly downstream of the AXI4-Lite register slave.
- Consumes the slave's per-register write_req/write_data strobes, which carry both bus writes and clear-on-read zero-writes.
- Returns registered contents on read_data.
- Arbitrates bus writes against a hardware-side update port from user logic (status/counter capture), including sticky status-bit semantics and collision reporting.

---
 rtl/reg_file_storage.sv | 72 +++++++
 tb/tb_reg_file_storage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_storage.sv
// reg_file_storage: per-register storage behind the AXI4-Lite register slave.
// Arbitrates bus writes against hardware updates, with sticky OR-accumulate and collision flags.
`default_nettype none

module reg_file_storage #(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_REGISTERS  = 16,
  parameter logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] RESET_VALUES  = '0,
  parameter logic [NUM_REGISTERS-1:0]                RO_MASK       = '0,
  parameter logic [NUM_REGISTERS-1:0]                HW_WRITE_MASK = '0,
  parameter logic [NUM_REGISTERS-1:0]                STICKY_MASK   = '0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REGISTERS-1:0]                i_bus_write_req,
  input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] i_bus_write_data,
  input  logic [NUM_REGISTERS-1:0]                i_hw_write_req,
  input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] i_hw_write_data,
  output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] o_read_data,
  output logic [NUM_REGISTERS-1:0]                o_bus_update,
  output logic [NUM_REGISTERS-1:0]                o_collision
);

  for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_reg
    localparam logic [REGISTER_WIDTH-1:0] RESET_VALUE = RESET_VALUES[i*REGISTER_WIDTH +: REGISTER_WIDTH];

    logic [REGISTER_WIDTH-1:0] value;
    logic [REGISTER_WIDTH-1:0] next_value;
    logic [REGISTER_WIDTH-1:0] bus_data;
    logic [REGISTER_WIDTH-1:0] hw_data;
    logic                      bus_acc;
    logic                      hw_acc;
    logic                      bus_update;
    logic                      collision;

    assign bus_data = i_bus_write_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
    assign hw_data  = i_hw_write_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
    assign bus_acc  = i_bus_write_req[i] & ~RO_MASK[i];
    assign hw_acc   = i_hw_write_req[i] & HW_WRITE_MASK[i];

    // Sticky registers keep hw-set bits even when a clear-on-read zero-write lands in the same cycle.
    always_comb begin
      next_value = value;
      if (bus_acc && hw_acc) begin
        next_value = STICKY_MASK[i] ? (bus_data | hw_data) : bus_data;
      end else if (bus_acc) begin
        next_value = bus_data;
      end else if (hw_acc) begin
        next_value = STICKY_MASK[i] ? (value | hw_data) : hw_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value      <= RESET_VALUE;
        bus_update <= 1'b0;
        collision  <= 1'b0;
      end else begin
        value      <= next_value;
        bus_update <= bus_acc;
        collision  <= bus_acc & hw_acc;
      end
    end

    assign o_read_data[i*REGISTER_WIDTH +: REGISTER_WIDTH] = value;
    assign o_bus_update[i] = bus_update;
    assign o_collision[i]  = collision;
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_storage.sv
// tb_reg_file_storage: directed plan checks plus randomized traffic against an array-based reference model.
`default_nettype none

module tb_reg_file_storage;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int FW = N * W;

  localparam logic [FW-1:0] RV = {32'h0000_0000, 32'h0000_0000, 32'h1111_2222, 32'h0000_0000,
                                  32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_00A5};
  localparam logic [N-1:0] RO  = 8'b0010_0000;
  localparam logic [N-1:0] HWM = 8'b1001_0010;
  localparam logic [N-1:0] STK = 8'b1000_0010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  breq = '0, hreq = '0;
  logic [FW-1:0] bdata = '0, hdata = '0;
  logic [FW-1:0] read_data;
  logic [N-1:0]  bus_update, collision;

  logic [W-1:0]  model [N];
  logic [N-1:0]  exp_upd, exp_col;
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  reg_file_storage #(
    .REGISTER_WIDTH(W), .NUM_REGISTERS(N), .RESET_VALUES(RV),
    .RO_MASK(RO), .HW_WRITE_MASK(HWM), .STICKY_MASK(STK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_bus_write_req(breq), .i_bus_write_data(bdata),
    .i_hw_write_req(hreq), .i_hw_write_data(hdata),
    .o_read_data(read_data), .o_bus_update(bus_update), .o_collision(collision)
  );

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = RV[i*W +: W];
    exp_upd = '0;
    exp_col = '0;
  endtask

  // Apply the register update rules to the inputs present at this edge.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit b = breq[i] && !RO[i];
      bit h = hreq[i] && HWM[i];
      logic [W-1:0] bd = bdata[i*W +: W];
      logic [W-1:0] hd = hdata[i*W +: W];
      if (b) model[i] = (h && STK[i]) ? (bd | hd) : bd;
      else if (h) model[i] = STK[i] ? (model[i] | hd) : hd;
      exp_upd[i] = b;
      exp_col[i] = b && h;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".read_data"}, read_data, model_flat());
    check({tag, ".bus_update"}, FW'(bus_update), FW'(exp_upd));
    check({tag, ".collision"}, FW'(collision), FW'(exp_col));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    breq = '0; hreq = '0; bdata = '0; hdata = '0;
  endtask

  task automatic bus_wr(input int r, input logic [W-1:0] d);
    breq[r] = 1'b1; bdata[r*W +: W] = d;
  endtask

  task automatic hw_wr(input int r, input logic [W-1:0] d);
    hreq[r] = 1'b1; hdata[r*W +: W] = d;
  endtask

  // Drops rst_n between edges, checks the immediate effect, then releases away from a rising edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1 check_all({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Plan 1: reset applied mid-cycle, before any rising edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset.reg0", FW'(read_data[0*W +: W]), FW'(32'h0000_00A5));
    check("reset.reg3", FW'(read_data[3*W +: W]), FW'(32'hDEAD_BEEF));
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");

    // Plan 2: single bus write.
    bus_wr(2, 32'h1234_5678);
    step("bus2");
    check("bus2.value", FW'(read_data[2*W +: W]), FW'(32'h1234_5678));
    check("bus2.pulse", FW'(bus_update), FW'(8'b0000_0100));
    idle();
    step("bus2.after");

    // Plan 3: RO and hw-mask gating.
    bus_wr(5, 32'hFFFF_FFFF);
    step("ro5");
    check("ro5.pulse", FW'(bus_update[5]), FW'(1'b0));
    idle();
    hw_wr(6, 32'h55);
    step("hw6.masked");
    check("hw6.value", FW'(read_data[6*W +: W]), FW'(32'h0));
    idle();

    // Plan 4: sticky accumulate then clear-on-read.
    hw_wr(1, 32'h01); step("stk.a");
    hw_wr(1, 32'h04); step("stk.b");
    check("stk.accum", FW'(read_data[1*W +: W]), FW'(32'h05));
    idle();
    bus_wr(1, 32'h0); step("stk.clear");
    check("stk.cleared", FW'(read_data[1*W +: W]), FW'(32'h0));
    check("stk.clear_pulse", FW'(bus_update[1]), FW'(1'b1));
    idle();

    // Plan 5: collisions on a sticky and a non-sticky register in the same cycle.
    bus_wr(1, 32'h0);    hw_wr(1, 32'h08);
    bus_wr(4, 32'hAAAA); hw_wr(4, 32'h5555);
    step("coll");
    check("coll.reg1", FW'(read_data[1*W +: W]), FW'(32'h08));
    check("coll.reg4", FW'(read_data[4*W +: W]), FW'(32'hAAAA));
    check("coll.flags", FW'(collision), FW'(8'b0001_0010));
    idle();
    step("coll.after");

    // Plan 6: reset in the middle of a held bus strobe.
    bus_wr(2, 32'h77);
    step("burst.a");
    step("burst.b");
    async_reset("burst");
    check("burst.reg2_reset", FW'(read_data[2*W +: W]), FW'(32'h0));
    step("burst.resume");
    check("burst.reg2", FW'(read_data[2*W +: W]), FW'(32'h77));
    check("burst.pulse", FW'(bus_update[2]), FW'(1'b1));
    idle();

    // Randomized traffic, including occasional reset between edges.
    for (int n = 0; n < 400; n++) begin
      breq = N'($urandom & $urandom);
      hreq = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        bdata[i*W +: W] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        hdata[i*W +: W] = ($urandom_range(0, 1) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
      end
      step("rand");
      if ($urandom_range(0, 49) == 0) async_reset("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
